// File: rtl/angle_cmd_sender.sv
// rtl/angle_cmd_sender.sv - shoot pulse then two-byte angle command into a uart_tx handshake
// Frame: shoot high SHOOT_CYCLES, high byte, GAP_CYCLES idle, low byte; aborts if tx_busy never rises.
module angle_cmd_sender #(
  parameter int SHOOT_CYCLES = 24,
  parameter int GAP_CYCLES   = 240,
  parameter int BUSY_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        msg_valid,
  input  logic [15:0] msg_data,
  output logic        msg_ready,
  output logic        start_tx,
  output logic [7:0]  data_to_tx,
  input  logic        tx_busy,
  output logic        shoot,
  output logic        done,
  output logic        timeout_err
);

  localparam int MAX_A = (SHOOT_CYCLES > GAP_CYCLES) ? SHOOT_CYCLES : GAP_CYCLES;
  localparam int MAX_P = (MAX_A > BUSY_TIMEOUT) ? MAX_A : BUSY_TIMEOUT;
  localparam int CW    = $clog2(MAX_P) + 1;

  localparam logic [CW-1:0] SHOOT_LAST = CW'(SHOOT_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] BUSY_LAST  = CW'(BUSY_TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX    = {CW{1'b1}};

  typedef enum logic [2:0] {
    IDLE, ARM, HI_ACK, HI_TX, GAP, LO_ACK, LO_TX
  } state_t;

  state_t          state, state_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic [15:0]     latch, latch_d;
  logic [7:0]      data_d;
  logic            shoot_d, start_d, done_d, tout_d;

  assign msg_ready = (state == IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      latch       <= '0;
      data_to_tx  <= '0;
      shoot       <= 1'b0;
      start_tx    <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      latch       <= latch_d;
      data_to_tx  <= data_d;
      shoot       <= shoot_d;
      start_tx    <= start_d;
      done        <= done_d;
      timeout_err <= tout_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    latch_d = latch;
    data_d  = data_to_tx;
    shoot_d = 1'b0;
    start_d = 1'b0;
    done_d  = 1'b0;
    tout_d  = 1'b0;
    case (state)
      IDLE: begin
        cnt_d = '0;
        if (msg_valid) begin
          latch_d = msg_data;
          shoot_d = 1'b1;
          state_d = ARM;
        end
      end
      ARM: begin
        shoot_d = 1'b1;
        if (cnt == SHOOT_LAST) begin
          shoot_d = 1'b0;
          data_d  = latch[15:8];
          start_d = 1'b1;
          cnt_d   = '0;
          state_d = HI_ACK;
        end
      end
      // busy already high on the start_tx cycle is taken as the acknowledge
      HI_ACK, LO_ACK: begin
        if (tx_busy) begin
          state_d = (state == HI_ACK) ? HI_TX : LO_TX;
        end else if (cnt == BUSY_LAST) begin
          tout_d  = 1'b1;
          state_d = IDLE;
        end
      end
      HI_TX: begin
        if (!tx_busy) begin
          cnt_d   = '0;
          state_d = GAP;
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          data_d  = latch[7:0];
          start_d = 1'b1;
          cnt_d   = '0;
          state_d = LO_ACK;
        end
      end
      LO_TX: begin
        if (!tx_busy) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_angle_cmd_sender.sv
// tb/tb_angle_cmd_sender.sv - directed bench for angle_cmd_sender with a simple uart_tx model
module tb_angle_cmd_sender;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        msg_valid = 1'b0;
  logic [15:0] msg_data = 16'h0000;
  logic        msg_ready;
  logic        start_tx;
  logic [7:0]  data_to_tx;
  logic        tx_busy = 1'b0;
  logic        shoot;
  logic        done;
  logic        timeout_err;

  angle_cmd_sender dut (
    .clk        (clk),
    .reset      (reset),
    .msg_valid  (msg_valid),
    .msg_data   (msg_data),
    .msg_ready  (msg_ready),
    .start_tx   (start_tx),
    .data_to_tx (data_to_tx),
    .tx_busy    (tx_busy),
    .shoot      (shoot),
    .done       (done),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  // uart model: 0 = never busy, 1 = busy one cycle after start_tx, 2 = busy already high at start_tx
  int uart_mode = 1;
  int busy_len  = 110;

  int         acc_q[$];
  int         st_cyc[$];
  logic [7:0] st_data[$];
  int         fall_q[$];
  int         done_q[$];
  int         shoot_cnt = 0;
  int         to_cnt = 0;
  int         to_cyc = 0;
  int         ready_viol = 0;
  logic       prev_busy = 1'b0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (start_tx && uart_mode != 0) begin
        if (uart_mode == 1) begin
          @(negedge clk);
          tx_busy = 1'b1;
        end
        repeat (busy_len) @(negedge clk);
        tx_busy = 1'b0;
      end else if (uart_mode == 2 && !msg_ready && !tx_busy) begin
        tx_busy = 1'b1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (msg_valid && msg_ready) acc_q.push_back(cyc);
      if (start_tx) begin
        st_cyc.push_back(cyc);
        st_data.push_back(data_to_tx);
      end
      if (shoot) shoot_cnt++;
      if (done) done_q.push_back(cyc);
      if (timeout_err) begin
        to_cnt++;
        to_cyc = cyc;
      end
      if (prev_busy && !tx_busy) fall_q.push_back(cyc);
      if (msg_ready && (shoot || start_tx)) ready_viol++;
      prev_busy = tx_busy;
    end
  end

  task automatic clear_log();
    acc_q.delete();
    st_cyc.delete();
    st_data.delete();
    fall_q.delete();
    done_q.delete();
    shoot_cnt  = 0;
    to_cnt     = 0;
    to_cyc     = 0;
    ready_viol = 0;
  endtask

  task automatic send(input logic [15:0] d);
    @(negedge clk);
    msg_data  = d;
    msg_valid = 1'b1;
    @(negedge clk);
    msg_valid = 1'b0;
  endtask

  task automatic wait_end(input int n_done, input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      #3;
      if (done_q.size() >= n_done || to_cnt > 0) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq({tag, "_bound"}, int'(ok), 1);
  endtask

  task automatic check_bytes(input string tag, input logic [15:0] exp);
    check_eq({tag, "_starts"}, st_data.size(), 2);
    if (st_data.size() >= 2) begin
      check_eq({tag, "_hi"}, int'(st_data[0]), int'(exp[15:8]));
      check_eq({tag, "_lo"}, int'(st_data[1]), int'(exp[7:0]));
    end
  endtask

  initial begin
    #1 reset = 1'b0;
    #12;
    check_eq("rst_ready", int'(msg_ready), 1);
    check_eq("rst_shoot", int'(shoot), 0);
    check_eq("rst_start", int'(start_tx), 0);
    check_eq("rst_data", int'(data_to_tx), 0);
    check_eq("rst_done", int'(done), 0);
    check_eq("rst_tout", int'(timeout_err), 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // 1: nominal frame
    uart_mode = 1;
    busy_len  = 110;
    clear_log();
    send(16'h0ABC);
    wait_end(1, "t1");
    repeat (5) @(negedge clk);
    check_bytes("t1", 16'h0ABC);
    check_eq("t1_shoot_len", shoot_cnt, 24);
    check_eq("t1_falls", fall_q.size(), 2);
    if (acc_q.size() >= 1 && st_cyc.size() >= 1)
      check_eq("t1_latency", st_cyc[0] - acc_q[0], 25);
    if (fall_q.size() >= 2 && st_cyc.size() >= 2) begin
      check_eq("t1_gap", st_cyc[1] - fall_q[0], 241);
      if (done_q.size() >= 1) check_eq("t1_done_at", done_q[0] - fall_q[1], 1);
    end
    check_eq("t1_done_cnt", done_q.size(), 1);
    check_eq("t1_tout_cnt", to_cnt, 0);

    // 2: uart never acknowledges
    uart_mode = 0;
    clear_log();
    send(16'h1234);
    wait_end(1, "t2");
    check_eq("t2_tout_seen", to_cnt, 1);
    if (st_cyc.size() >= 1) check_eq("t2_tout_at", to_cyc - st_cyc[0], 1024);
    @(negedge clk);
    #3;
    check_eq("t2_shoot", int'(shoot), 0);
    check_eq("t2_ready", int'(msg_ready), 1);
    check_eq("t2_tout_pulse", int'(timeout_err), 0);
    repeat (5) @(negedge clk);
    check_eq("t2_starts", st_cyc.size(), 1);
    check_eq("t2_done_cnt", done_q.size(), 0);
    check_eq("t2_tout_cnt", to_cnt, 1);

    // 3: msg_valid held high across two frames
    uart_mode = 1;
    busy_len  = 20;
    clear_log();
    @(negedge clk);
    msg_data  = 16'h0001;
    msg_valid = 1'b1;
    for (int i = 0; i < 100 && acc_q.size() < 1; i++) begin
      @(negedge clk);
      #3;
    end
    @(negedge clk);
    msg_data = 16'h0FFF;
    for (int i = 0; i < 2000 && acc_q.size() < 2; i++) begin
      @(negedge clk);
      #3;
    end
    @(negedge clk);
    msg_valid = 1'b0;
    wait_end(2, "t3");
    repeat (5) @(negedge clk);
    check_eq("t3_accepts", acc_q.size(), 2);
    check_eq("t3_starts", st_data.size(), 4);
    if (st_data.size() >= 4) begin
      check_eq("t3_b0", int'(st_data[0]), 'h00);
      check_eq("t3_b1", int'(st_data[1]), 'h01);
      check_eq("t3_b2", int'(st_data[2]), 'h0F);
      check_eq("t3_b3", int'(st_data[3]), 'hFF);
    end
    check_eq("t3_done_cnt", done_q.size(), 2);
    check_eq("t3_ready_busy", ready_viol, 0);

    // 4: reset during GAP, then a fresh frame
    busy_len = 50;
    clear_log();
    send(16'h5555);
    for (int i = 0; i < 500 && fall_q.size() < 1; i++) begin
      @(negedge clk);
      #3;
    end
    check_eq("t4_in_gap", fall_q.size(), 1);
    repeat (50) @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("t4_shoot", int'(shoot), 0);
    check_eq("t4_start", int'(start_tx), 0);
    check_eq("t4_ready", int'(msg_ready), 1);
    check_eq("t4_done", int'(done), 0);
    check_eq("t4_tout", int'(timeout_err), 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (300) @(negedge clk);
    check_eq("t4_no_done", done_q.size(), 0);
    check_eq("t4_one_start", st_cyc.size(), 1);
    clear_log();
    send(16'h0A5C);
    wait_end(1, "t4b");
    repeat (5) @(negedge clk);
    check_bytes("t4b", 16'h0A5C);
    check_eq("t4b_done_cnt", done_q.size(), 1);

    // 5: msg_data changes during ARM
    busy_len = 30;
    clear_log();
    send(16'h0123);
    repeat (5) @(negedge clk);
    msg_data = 16'hFFFF;
    wait_end(1, "t5");
    repeat (5) @(negedge clk);
    check_bytes("t5", 16'h0123);
    check_eq("t5_done_cnt", done_q.size(), 1);

    // 6: tx_busy already high when start_tx asserts
    uart_mode = 2;
    busy_len  = 40;
    clear_log();
    send(16'h0C3A);
    wait_end(1, "t6");
    repeat (5) @(negedge clk);
    check_bytes("t6", 16'h0C3A);
    check_eq("t6_tout_cnt", to_cnt, 0);
    check_eq("t6_done_cnt", done_q.size(), 1);
    uart_mode = 1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
